rpm_error_calc: RTL and testbench
=================================

# rpm_error_calc

Upstream stage of the wheel-speed PI loop. Decodes one quadrature encoder, counts edges over a fixed sample window, and subtracts the measured speed from the commanded setpoint. It publishes the 17-bit sign-magnitude Q8 error word the PI controller consumes. It also generates the controller's sample tick, so every PI iteration sees a freshly settled error.

## Interface
- `WINDOW_CYCLES`, default 500000: clock cycles per sample window (10 ms at 50 MHz).
- `COUNT_WIDTH`, default 16: width of the signed two's-complement edge counter.
- `N_WIDTH`, default 17: error/setpoint word width (1 sign + 8 integer + 8 fraction).
- `Q_WIDTH`, default 8: fractional bits.

- `clk` in 1: system clock. One clock domain.
- `reset` in 1: asynchronous, active-high reset.
- `enc_a`, `enc_b` in 1 each: raw encoder channels, asynchronous.
- `setpoint` in N_WIDTH: commanded counts/window, sign-magnitude Q8.
- `enable` in 1: when low, the published error is forced to +0.
- `error_k` out N_WIDTH: setpoint − measured, sign-magnitude Q8, saturated.
- `meas_count` out COUNT_WIDTH: signed edge count of the last completed window.
- `error_valid` out 1: one-cycle pulse on the cycle `error_k` updates.
- `pi_tick` out 1: registered one-cycle pulse, one cycle after `error_valid`. It drives the PI sample clock.
- `enc_fault` out 1: sticky illegal-transition flag. Only `reset` clears it.

## Operation
- Inputs: `enc_a`/`enc_b` each pass a 2-FF synchronizer. The decoder compares the previous and current synchronized {A,B}.
- Decoding is 4x:
  - Gray-adjacent step 00→01→11→10→00 counts +1; the reverse order counts −1.
  - No change: no count.
  - Both bits change: no count, and `enc_fault` is set.
- The edge counter saturates at ±(2^(COUNT_WIDTH−1)−1). It never wraps.
- The window counter runs 0..WINDOW_CYCLES−1 continuously.
- At terminal count (LATCH), in the same cycle:
  - the edge count is snapshotted;
  - the counter restarts at the current cycle's decoded step (0 or ±1), so no edge is lost;
  - `setpoint` is sampled.
- FSM states: COUNT → LATCH → CONVERT → SUBTRACT → PUBLISH → COUNT. Each non-COUNT state lasts one cycle. Window length WINDOW_CYCLES ≥ 8 is required.
- CONVERT: the snapshot becomes measured speed in sign-magnitude Q8. The magnitude's integer part is clamped to 255 and its fraction is 0.
- SUBTRACT:
  - Setpoint and measured are converted to 18-bit two's complement, then setpoint − measured is computed.
  - The result saturates to magnitude 2^16−1 and converts back to sign-magnitude.
  - A zero result is always emitted as +0 (0x00000). Incoming −0 is treated as 0.
- PUBLISH: registers `error_k` and `meas_count` and pulses `error_valid`. If `enable`=0, `error_k` ← 0.
- Reset mid-window discards the partial count. No publish occurs until a full window completes.

## Timing
- Reset values: `error_k`=0, `meas_count`=0, `error_valid`=0, `pi_tick`=0, `enc_fault`=0. FSM starts in COUNT with the window counter at 0.
- Encoder-pin-to-count latency: 3 cycles (2 sync stages + decode register).
- LATCH occurs at window count WINDOW_CYCLES−1.
- `error_valid` fires 3 cycles after LATCH. `pi_tick` fires 4 cycles after LATCH.
- `error_k` is stable between `error_valid` pulses, i.e. one full window.
- A setpoint change is reflected only at the next LATCH.

## Configuration
- `RPM_ERR_FILTER_EN` defined: CONVERT uses (current + previous snapshot)/2. The halving is an arithmetic shift with magnitude truncation toward zero. The previous snapshot resets to 0. Latency is unchanged.
- `RPM_ERR_FILTER_EN` undefined: raw snapshot only. No history register.

## Structure
- Shared package/include `rpm_pkg`:
  - N_WIDTH and Q_WIDTH defaults;
  - FSM state encoding;
  - SAT_MAG constant (2^16−1);
  - sign-magnitude ↔ two's-complement conversion functions, which are reused by PI-side blocks.
- One sub-module, `quad_decoder`: synchronizers, transition decode, `step` (−1/0/+1) output and fault output.

## Test plan
Setup for all scenarios: WINDOW_CYCLES=100, `enable`=1.

- Setpoint 0x00A00 (+10.0); 6 forward edges in one window → `meas_count`=6, `error_k`=0x00400 (+4.0). `error_valid` fires at LATCH+3 and `pi_tick` at LATCH+4.
- Setpoint +10.0; 6 reverse edges → `meas_count`=−6, `error_k`=0x01000 (+16.0).
- Setpoint 0x1C800 (−200.0); 100 forward edges → result −300, saturated to `error_k`=0x1FFFF.
- Inject {A,B} 00→11 → count unchanged and `enc_fault`=1. The flag holds through later windows and clears only on `reset`.
- Assert `reset` at cycle 50 of a window with 3 edges counted → all outputs 0. The next publish reflects only post-reset edges.
- With `RPM_ERR_FILTER_EN`: windows of 4 then 8 edges, setpoint +6.0 → second publish has measured 6, `error_k`=0x00000.

Source files
------------

// File: rtl/rpm_pkg.sv
// Shared types and sign-magnitude helpers for the wheel-speed PI loop.
package rpm_pkg;

  localparam int DEF_N_WIDTH = 17;
  localparam int DEF_Q_WIDTH = 8;
  localparam int TC_WIDTH    = DEF_N_WIDTH + 1;
  localparam int unsigned SAT_MAG = (2 ** 16) - 1;

  // Two-bit signed step codes produced by the quadrature decoder.
  localparam logic [1:0] STEP_NONE = 2'b00;
  localparam logic [1:0] STEP_FWD  = 2'b01;
  localparam logic [1:0] STEP_REV  = 2'b11;

  typedef enum logic [2:0] {
    ST_COUNT,
    ST_LATCH,
    ST_CONVERT,
    ST_SUBTRACT,
    ST_PUBLISH
  } state_t;

  // Sign-magnitude to two's complement; -0 maps to 0.
  function automatic logic signed [TC_WIDTH-1:0] sm_to_tc(input logic [DEF_N_WIDTH-1:0] sm);
    logic signed [TC_WIDTH-1:0] mag;
    mag = {2'b00, sm[DEF_N_WIDTH-2:0]};
    return sm[DEF_N_WIDTH-1] ? -mag : mag;
  endfunction

  // Two's complement to sign-magnitude, magnitude saturated to SAT_MAG; zero is always +0.
  function automatic logic [DEF_N_WIDTH-1:0] tc_to_sm_sat(input logic signed [TC_WIDTH-1:0] v);
    logic [TC_WIDTH-1:0]    mag;
    logic [DEF_N_WIDTH-1:0] sm;
    mag = v[TC_WIDTH-1] ? TC_WIDTH'(-v) : TC_WIDTH'(v);
    if (mag > TC_WIDTH'(SAT_MAG)) begin
      mag = TC_WIDTH'(SAT_MAG);
    end
    if (mag == '0) begin
      sm = '0;
    end else begin
      sm = {v[TC_WIDTH-1], mag[DEF_N_WIDTH-2:0]};
    end
    return sm;
  endfunction

endpackage

// File: rtl/rpm_error_calc_quad_decoder.sv
// 4x quadrature decoder: 2-FF synchronizers, transition decode, sticky fault.
module quad_decoder
  import rpm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       enc_a,
  input  logic       enc_b,
  output logic [1:0] step,
  output logic       fault
);

  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] ab_prev;
  logic       illegal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1   <= '0;
      sync2   <= '0;
      ab_prev <= '0;
      fault   <= 1'b0;
    end else begin
      sync1   <= {enc_a, enc_b};
      sync2   <= sync1;
      ab_prev <= sync2;
      if (illegal) begin
        fault <= 1'b1;
      end
    end
  end

  always_comb begin
    step    = STEP_NONE;
    illegal = 1'b0;
    case ({ab_prev, sync2})
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step = STEP_FWD;
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step = STEP_REV;
      4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/rpm_error_calc.sv
// Encoder speed measurement and setpoint error for the PI loop.
// Optional: RPM_ERR_FILTER_EN averages current and previous window snapshots.
module rpm_error_calc
  import rpm_pkg::*;
#(
  parameter int WINDOW_CYCLES = 500000,
  parameter int COUNT_WIDTH   = 16,
  parameter int N_WIDTH       = DEF_N_WIDTH,
  parameter int Q_WIDTH       = DEF_Q_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enc_a,
  input  logic                   enc_b,
  input  logic [N_WIDTH-1:0]     setpoint,
  input  logic                   enable,
  output logic [N_WIDTH-1:0]     error_k,
  output logic [COUNT_WIDTH-1:0] meas_count,
  output logic                   error_valid,
  output logic                   pi_tick,
  output logic                   enc_fault
);

  localparam int WIN_W = $clog2(WINDOW_CYCLES);
  localparam int INT_W = N_WIDTH - 1 - Q_WIDTH;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [WIN_W-1:0] WIN_PRE  = WIN_W'(WINDOW_CYCLES - 2);
  localparam logic signed [COUNT_WIDTH-1:0] CNT_MAX = COUNT_WIDTH'((2 ** (COUNT_WIDTH - 1)) - 1);
  localparam logic signed [COUNT_WIDTH-1:0] CNT_MIN = -CNT_MAX;
  localparam logic [INT_W-1:0] INT_MAX = '1;

  state_t state;
  state_t state_next;
  logic   latch_en;
  logic   convert_en;
  logic   load_en;

  logic [WIN_W-1:0]              win_cnt;
  logic [1:0]                    step;
  logic signed [COUNT_WIDTH-1:0] step_ext;
  logic signed [COUNT_WIDTH-1:0] edge_cnt;
  logic signed [COUNT_WIDTH-1:0] edge_next;
  logic signed [COUNT_WIDTH-1:0] snap;
  logic signed [COUNT_WIDTH-1:0] meas_val;
  logic [COUNT_WIDTH-1:0]        meas_abs;
  logic [INT_W-1:0]              meas_int;
  logic [N_WIDTH-1:0]            sp_reg;
  logic [N_WIDTH-1:0]            meas_sm;
  logic [N_WIDTH-1:0]            meas_sm_next;
  logic [N_WIDTH-1:0]            err_next;
  logic signed [TC_WIDTH-1:0]    diff;

  quad_decoder u_dec (
    .clk   (clk),
    .reset (reset),
    .enc_a (enc_a),
    .enc_b (enc_b),
    .step  (step),
    .fault (enc_fault)
  );

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_COUNT;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state; LATCH lines up with the window's terminal count
  always_comb begin
    state_next = state;
    case (state)
      ST_COUNT:    if (win_cnt == WIN_PRE) state_next = ST_LATCH;
      ST_LATCH:    state_next = ST_CONVERT;
      ST_CONVERT:  state_next = ST_SUBTRACT;
      ST_SUBTRACT: state_next = ST_PUBLISH;
      ST_PUBLISH:  state_next = ST_COUNT;
      default:     state_next = ST_COUNT;
    endcase
  end

  // FSM outputs
  always_comb begin
    latch_en    = (state == ST_LATCH);
    convert_en  = (state == ST_CONVERT);
    load_en     = (state == ST_SUBTRACT);
    error_valid = (state == ST_PUBLISH);
  end

  // Free-running sample window counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_cnt <= '0;
    end else if (win_cnt == WIN_LAST) begin
      win_cnt <= '0;
    end else begin
      win_cnt <= win_cnt + 1'b1;
    end
  end

  // Saturating next edge count
  always_comb begin
    step_ext  = {{(COUNT_WIDTH - 2){step[1]}}, step};
    edge_next = edge_cnt + step_ext;
    if ((step == STEP_FWD && edge_cnt == CNT_MAX) ||
        (step == STEP_REV && edge_cnt == CNT_MIN)) begin
      edge_next = edge_cnt;
    end
  end

  // Edge counter, snapshot and setpoint sample; restart keeps this cycle's step
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edge_cnt <= '0;
      snap     <= '0;
      sp_reg   <= '0;
    end else if (latch_en) begin
      snap     <= edge_cnt;
      edge_cnt <= step_ext;
      sp_reg   <= setpoint;
    end else begin
      edge_cnt <= edge_next;
    end
  end

`ifdef RPM_ERR_FILTER_EN
  localparam logic signed [COUNT_WIDTH:0] SUM_ONE = 1;
  logic signed [COUNT_WIDTH-1:0] prev_snap;
  logic signed [COUNT_WIDTH:0]   pair_sum;

  // Previous snapshot history
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_snap <= '0;
    end else if (convert_en) begin
      prev_snap <= snap;
    end
  end

  // Two-window average, negative sums biased so the halving truncates toward zero
  always_comb begin
    pair_sum = {snap[COUNT_WIDTH-1], snap} + {prev_snap[COUNT_WIDTH-1], prev_snap};
    if (pair_sum[COUNT_WIDTH]) begin
      meas_val = COUNT_WIDTH'((pair_sum + SUM_ONE) >>> 1);
    end else begin
      meas_val = COUNT_WIDTH'(pair_sum >>> 1);
    end
  end
`else
  // Raw snapshot is the measurement
  always_comb begin
    meas_val = snap;
  end
`endif

  // Measured speed to sign-magnitude Q8, integer part clamped
  always_comb begin
    meas_abs     = meas_val[COUNT_WIDTH-1] ? COUNT_WIDTH'(-meas_val) : COUNT_WIDTH'(meas_val);
    meas_int     = (meas_abs > COUNT_WIDTH'(INT_MAX)) ? INT_MAX : meas_abs[INT_W-1:0];
    meas_sm_next = {meas_val[COUNT_WIDTH-1], meas_int, {Q_WIDTH{1'b0}}};
  end

  // Saturated setpoint - measured
  always_comb begin
    diff     = sm_to_tc(sp_reg) - sm_to_tc(meas_sm);
    err_next = tc_to_sm_sat(diff);
  end

  // Output registers load on the SUBTRACT->PUBLISH edge so error_k changes with error_valid
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meas_sm    <= '0;
      error_k    <= '0;
      meas_count <= '0;
      pi_tick    <= 1'b0;
    end else begin
      pi_tick <= error_valid;
      if (convert_en) begin
        meas_sm <= meas_sm_next;
      end
      if (load_en) begin
        error_k    <= enable ? err_next : '0;
        meas_count <= snap;
      end
    end
  end

endmodule

// File: tb/tb_rpm_error_calc.sv
// Directed self-checking bench for rpm_error_calc (WINDOW_CYCLES = 100).
module tb_rpm_error_calc;

  logic        clk = 1'b0;
  logic        reset;
  logic        enc_a;
  logic        enc_b;
  logic [16:0] setpoint;
  logic        enable;
  logic [16:0] error_k;
  logic [15:0] meas_count;
  logic        error_valid;
  logic        pi_tick;
  logic        enc_fault;

  logic [1:0]  ab;
  int          checks = 0;
  int          errors = 0;

  assign enc_a = ab[1];
  assign enc_b = ab[0];

  always #5 clk = ~clk;

  rpm_error_calc #(.WINDOW_CYCLES(100)) dut (
    .clk         (clk),
    .reset       (reset),
    .enc_a       (enc_a),
    .enc_b       (enc_b),
    .setpoint    (setpoint),
    .enable      (enable),
    .error_k     (error_k),
    .meas_count  (meas_count),
    .error_valid (error_valid),
    .pi_tick     (pi_tick),
    .enc_fault   (enc_fault)
  );

  function automatic logic [1:0] fwd_of(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] rev_of(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  task automatic edges(input int n, input bit forward, input int hold);
    for (int i = 0; i < n; i++) begin
      ab = forward ? fwd_of(ab) : rev_of(ab);
      repeat (hold) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_valid(output bit ok, output int n);
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 300) begin
      @(posedge clk);
      #1;
      n++;
      if (error_valid) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    bit ok;
    int n;
    reset = 1'b1; ab = 2'b00; setpoint = 17'h00A00; enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (error_k !== 17'h0) begin errors++; $display("FAIL rst_error_k got %h exp %h", error_k, 17'h0); end
    checks++; if (meas_count !== 16'h0) begin errors++; $display("FAIL rst_meas got %h exp %h", meas_count, 16'h0); end
    checks++; if (error_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", error_valid); end
    checks++; if (pi_tick !== 1'b0) begin errors++; $display("FAIL rst_pi_tick got %b exp 0", pi_tick); end
    checks++; if (enc_fault !== 1'b0) begin errors++; $display("FAIL rst_fault got %b exp 0", enc_fault); end
    reset = 1'b0;
    wait_valid(ok, n);
    checks++; if (!ok) begin errors++; $display("FAIL first_valid_timeout got %0d exp valid", n); end
    checks++; if (n !== 102) begin errors++; $display("FAIL first_valid_cycle got %0d exp %0d", n, 102); end
    checks++; if (meas_count !== 16'h0) begin errors++; $display("FAIL first_meas got %h exp %h", meas_count, 16'h0); end
    checks++; if (error_k !== 17'h00A00) begin errors++; $display("FAIL first_error got %h exp %h", error_k, 17'h00A00); end
    checks++; if (pi_tick !== 1'b0) begin errors++; $display("FAIL tick_early got %b exp 0", pi_tick); end
    @(posedge clk);
    #1;
    checks++; if (pi_tick !== 1'b1) begin errors++; $display("FAIL tick_after_valid got %b exp 1", pi_tick); end
    checks++; if (error_valid !== 1'b0) begin errors++; $display("FAIL valid_width got %b exp 0", error_valid); end
  endtask

  task automatic test_forward;
    bit ok;
    int n;
    edges(6, 1'b1, 4);
    wait_valid(ok, n);
    checks++; if (!ok) begin errors++; $display("FAIL fwd_timeout got %0d exp valid", n); end
    checks++; if (1 + 24 + n !== 100) begin errors++; $display("FAIL window_period got %0d exp %0d", 1 + 24 + n, 100); end
    checks++; if (meas_count !== 16'd6) begin errors++; $display("FAIL fwd_meas got %h exp %h", meas_count, 16'd6); end
    checks++; if (error_k !== 17'h00400) begin errors++; $display("FAIL fwd_error got %h exp %h", error_k, 17'h00400); end
    @(posedge clk);
    #1;
    checks++; if (pi_tick !== 1'b1) begin errors++; $display("FAIL fwd_tick got %b exp 1", pi_tick); end
  endtask

  task automatic test_reverse;
    bit ok;
    int n;
    edges(6, 1'b0, 4);
    wait_valid(ok, n);
    checks++; if (!ok) begin errors++; $display("FAIL rev_timeout got %0d exp valid", n); end
    checks++; if (meas_count !== 16'hFFFA) begin errors++; $display("FAIL rev_meas got %h exp %h", meas_count, 16'hFFFA); end
    checks++; if (error_k !== 17'h01000) begin errors++; $display("FAIL rev_error got %h exp %h", error_k, 17'h01000); end
  endtask

  task automatic test_saturate;
    bit ok;
    int n;
    setpoint = 17'h1C800;
    edges(55, 1'b1, 1);
    wait_valid(ok, n);
    checks++; if (!ok) begin errors++; $display("FAIL sat_edge_timeout got %0d exp valid", n); end
    checks++; if (meas_count !== 16'd55) begin errors++; $display("FAIL sat_edge_meas got %h exp %h", meas_count, 16'd55); end
    checks++; if (error_k !== 17'h1FF00) begin errors++; $display("FAIL sat_edge_error got %h exp %h", error_k, 17'h1FF00); end
    edges(60, 1'b1, 1);
    wait_valid(ok, n);
    checks++; if (!ok) begin errors++; $display("FAIL sat_timeout got %0d exp valid", n); end
    checks++; if (meas_count !== 16'd60) begin errors++; $display("FAIL sat_meas got %h exp %h", meas_count, 16'd60); end
    checks++; if (error_k !== 17'h1FFFF) begin errors++; $display("FAIL sat_error got %h exp %h", error_k, 17'h1FFFF); end
  endtask

  task automatic test_setpoint_hold;
    bit ok;
    int n;
    bit stable;
    setpoint = 17'h00A00;
    stable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (error_k !== 17'h1FFFF) stable = 1'b0;
    end
    checks++; if (stable !== 1'b1) begin errors++; $display("FAIL hold_stable got %h exp %h", error_k, 17'h1FFFF); end
    wait_valid(ok, n);
    checks++; if (!ok) begin errors++; $display("FAIL hold_timeout got %0d exp valid", n); end
    checks++; if (error_k !== 17'h00A00) begin errors++; $display("FAIL hold_new_sp got %h exp %h", error_k, 17'h00A00); end
  endtask

  task automatic test_fault;
    bit ok;
    int n;
    checks++; if (enc_fault !== 1'b0) begin errors++; $display("FAIL fault_clean got %b exp 0", enc_fault); end
    edges(1, 1'b1, 2);
    ab = 2'b11;
    repeat (2) begin @(posedge clk); #1; end
    edges(2, 1'b1, 2);
    checks++; if (enc_fault !== 1'b1) begin errors++; $display("FAIL fault_set got %b exp 1", enc_fault); end
    wait_valid(ok, n);
    checks++; if (!ok) begin errors++; $display("FAIL fault_timeout got %0d exp valid", n); end
    checks++; if (meas_count !== 16'd3) begin errors++; $display("FAIL fault_meas got %h exp %h", meas_count, 16'd3); end
    checks++; if (error_k !== 17'h00700) begin errors++; $display("FAIL fault_error got %h exp %h", error_k, 17'h00700); end
    wait_valid(ok, n);
    checks++; if (!ok) begin errors++; $display("FAIL fault2_timeout got %0d exp valid", n); end
    checks++; if (meas_count !== 16'd0) begin errors++; $display("FAIL fault2_meas got %h exp %h", meas_count, 16'd0); end
    checks++; if (enc_fault !== 1'b1) begin errors++; $display("FAIL fault_sticky got %b exp 1", enc_fault); end
  endtask

  task automatic test_enable;
    bit ok;
    int n;
    enable = 1'b0;
    edges(1, 1'b1, 2);
    wait_valid(ok, n);
    checks++; if (!ok) begin errors++; $display("FAIL en_timeout got %0d exp valid", n); end
    checks++; if (error_k !== 17'h0) begin errors++; $display("FAIL en_forced_zero got %h exp %h", error_k, 17'h0); end
    checks++; if (meas_count !== 16'd1) begin errors++; $display("FAIL en_meas got %h exp %h", meas_count, 16'd1); end
    enable = 1'b1;
    wait_valid(ok, n);
    checks++; if (!ok) begin errors++; $display("FAIL en2_timeout got %0d exp valid", n); end
    checks++; if (error_k !== 17'h00A00) begin errors++; $display("FAIL en_restored got %h exp %h", error_k, 17'h00A00); end
  endtask

  task automatic test_zero;
    bit ok;
    int n;
    setpoint = 17'h00200;
    edges(2, 1'b1, 2);
    wait_valid(ok, n);
    checks++; if (!ok) begin errors++; $display("FAIL zero_timeout got %0d exp valid", n); end
    checks++; if (error_k !== 17'h0) begin errors++; $display("FAIL zero_error got %h exp %h", error_k, 17'h0); end
    setpoint = 17'h10000;
    wait_valid(ok, n);
    checks++; if (!ok) begin errors++; $display("FAIL negzero_timeout got %0d exp valid", n); end
    checks++; if (error_k !== 17'h0) begin errors++; $display("FAIL negzero_error got %h exp %h", error_k, 17'h0); end
  endtask

  task automatic test_reset_midwindow;
    bit ok;
    int n;
    setpoint = 17'h00A00;
    edges(3, 1'b1, 2);
    repeat (42) begin @(posedge clk); #1; end
    checks++; if (enc_fault !== 1'b1) begin errors++; $display("FAIL fault_before_reset got %b exp 1", enc_fault); end
    reset = 1'b1;
    #1;
    checks++; if (error_k !== 17'h0) begin errors++; $display("FAIL mid_rst_error got %h exp %h", error_k, 17'h0); end
    checks++; if (meas_count !== 16'h0) begin errors++; $display("FAIL mid_rst_meas got %h exp %h", meas_count, 16'h0); end
    checks++; if (enc_fault !== 1'b0) begin errors++; $display("FAIL mid_rst_fault got %b exp 0", enc_fault); end
    ab = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    edges(2, 1'b1, 2);
    wait_valid(ok, n);
    checks++; if (!ok) begin errors++; $display("FAIL post_rst_timeout got %0d exp valid", n); end
    checks++; if (4 + n !== 102) begin errors++; $display("FAIL post_rst_cycle got %0d exp %0d", 4 + n, 102); end
    checks++; if (meas_count !== 16'd2) begin errors++; $display("FAIL post_rst_meas got %h exp %h", meas_count, 16'd2); end
    checks++; if (error_k !== 17'h00800) begin errors++; $display("FAIL post_rst_error got %h exp %h", error_k, 17'h00800); end
  endtask

  task automatic test_filter;
    bit ok;
    int n;
    setpoint = 17'h00600;
    edges(4, 1'b1, 2);
    wait_valid(ok, n);
    checks++; if (!ok) begin errors++; $display("FAIL filt1_timeout got %0d exp valid", n); end
    checks++; if (meas_count !== 16'd4) begin errors++; $display("FAIL filt1_meas got %h exp %h", meas_count, 16'd4); end
    checks++; if (error_k !== 17'h00400) begin errors++; $display("FAIL filt1_error got %h exp %h", error_k, 17'h00400); end
    edges(8, 1'b1, 2);
    wait_valid(ok, n);
    checks++; if (!ok) begin errors++; $display("FAIL filt2_timeout got %0d exp valid", n); end
    checks++; if (meas_count !== 16'd8) begin errors++; $display("FAIL filt2_meas got %h exp %h", meas_count, 16'd8); end
    checks++; if (error_k !== 17'h0) begin errors++; $display("FAIL filt2_error got %h exp %h", error_k, 17'h0); end
  endtask

  initial begin
    test_reset;
`ifdef RPM_ERR_FILTER_EN
    test_filter;
`else
    test_forward;
    test_reverse;
    test_saturate;
    test_setpoint_hold;
    test_fault;
    test_enable;
    test_zero;
    test_reset_midwindow;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
